// File: rtl/seq_pattern_detector_if.sv
// ============================================================================
// Module   : seq_pattern_detector_if
// Brief    : Serial stream, configuration and status bundle for the detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seq_pattern_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             din_valid;
    logic             din;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic [LEN_W-1:0] cur_len;

    modport master (
        output din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  match, match_cnt, cur_len
    );

    modport slave (
        input  din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output match, match_cnt, cur_len
    );
endinterface

`default_nettype wire

// File: rtl/seq_pattern_detector.sv
// ============================================================================
// Module   : seq_pattern_detector
// Brief    : Runtime-programmable serial pattern detector with match counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_pattern_detector #(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = 4'b1011
) (
    input  wire logic              clk,
    input  wire logic              rst,
    seq_pattern_detector_if.slave  sp
);
    localparam int               LEN_W     = $clog2(PAT_W) + 1;
    localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;

    logic [LEN_W-1:0] w_len_clamped;
    logic [PAT_W-1:0] w_shift;
    logic [PAT_W-1:0] w_mask;
    logic             w_full;
    logic             w_take;
    logic             w_hit;
    logic [LEN_W-1:0] w_fill_next;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_len_clamped = sp.cfg_len;
        if (sp.cfg_len == '0)
            w_len_clamped = LEN_W'(1);
        else if (sp.cfg_len > C_LEN_MAX)
            w_len_clamped = C_LEN_MAX;
    end

    // Compare against the shifted-in window so the current bit participates.
    assign w_shift = {r_hist[PAT_W-2:0], sp.din};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++)
            w_mask[i] = (i < int'(r_len));
    end

    assign w_full = ({1'b0, r_fill} + 1'b1) >= {1'b0, r_len};
    assign w_take = sp.din_valid & ~sp.cfg_load;
    assign w_hit  = w_take & w_full & (((w_shift ^ r_pattern) & w_mask) == '0);

    always_comb begin
        w_fill_next = (r_fill < r_len) ? r_fill + 1'b1 : r_len;
        if (w_hit && !r_overlap)
            w_fill_next = '0;
    end

    // Clear is applied before the increment so a coincident match still counts.
    assign w_cnt_base = sp.cnt_clr ? '0 : r_cnt;
    assign w_cnt_next = (w_hit && (w_cnt_base != C_CNT_MAX)) ? w_cnt_base + 1'b1 : w_cnt_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= RST_PATTERN;
            r_len     <= C_LEN_MAX;
            r_overlap <= 1'b1;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_match <= w_hit;
            r_cnt   <= w_cnt_next;
            if (sp.cfg_load) begin
                r_pattern <= sp.cfg_pattern;
                r_len     <= w_len_clamped;
                r_overlap <= sp.cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
            end else if (sp.din_valid) begin
                r_hist <= w_shift;
                r_fill <= w_fill_next;
            end
        end
    end

    assign sp.match     = r_match;
    assign sp.match_cnt = r_cnt;
    assign sp.cur_len   = r_len;
endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
// ============================================================================
// Module   : tb_seq_pattern_detector
// Brief    : Randomised and directed bench against a bit-queue reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_pattern_detector;
    localparam int PAT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       t_valid, t_din, t_load, t_ovl, t_clr;
    logic [3:0] t_pat;
    logic [2:0] t_len;

    int checks   = 0;
    int failures = 0;

    seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(8)) sp8 ();
    seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(2)) sp2 ();

    assign sp8.din_valid = t_valid;   assign sp2.din_valid = t_valid;
    assign sp8.din = t_din;           assign sp2.din = t_din;
    assign sp8.cfg_load = t_load;     assign sp2.cfg_load = t_load;
    assign sp8.cfg_pattern = t_pat;   assign sp2.cfg_pattern = t_pat;
    assign sp8.cfg_len = t_len;       assign sp2.cfg_len = t_len;
    assign sp8.cfg_overlap = t_ovl;   assign sp2.cfg_overlap = t_ovl;
    assign sp8.cnt_clr = t_clr;       assign sp2.cnt_clr = t_clr;

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8), .RST_PATTERN(4'b1011)) u_dut8 (
        .clk (clk), .rst (rst), .sp (sp8.slave));
    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2), .RST_PATTERN(4'b1011)) u_dut2 (
        .clk (clk), .rst (rst), .sp (sp2.slave));

    always #5 clk = ~clk;

    // Reference model: the valid bits seen since the last window restart.
    bit       q[$];
    bit [3:0] m_pat;
    int       m_len;
    bit       m_ovl;
    bit       m_hit;
    int       m_cnt8, m_cnt2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input bit d, input bit ld, input bit [3:0] p,
                              input bit [2:0] l, input bit o, input bit c, input bit r);
        m_hit = 1'b0;
        if (r) begin
            q.delete();
            m_pat = 4'b1011; m_len = PAT_W; m_ovl = 1'b1;
            m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        if (ld) begin
            m_pat = p; m_ovl = o;
            m_len = (l == 0) ? 1 : ((l > PAT_W) ? PAT_W : int'(l));
            q.delete();
        end else if (v) begin
            q.push_back(d);
            if (q.size() > 16) void'(q.pop_front());
            if (q.size() >= m_len) begin
                m_hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) m_hit = 1'b0;
            end
            if (m_hit && !m_ovl) q.delete();
        end
        if (c) begin m_cnt8 = 0; m_cnt2 = 0; end
        if (m_hit) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
        end
    endtask

    task automatic step(input bit v, input bit d, input bit ld, input bit [3:0] p,
                        input bit [2:0] l, input bit o, input bit c, input bit r);
        @(negedge clk);
        t_valid = v; t_din = d; t_load = ld; t_pat = p; t_len = l; t_ovl = o; t_clr = c; rst = r;
        @(posedge clk);
        model_edge(v, d, ld, p, l, o, c, r);
        #1;
        check("match8", 32'(sp8.match), 32'(m_hit));
        check("match2", 32'(sp2.match), 32'(m_hit));
        check("cnt8", 32'(sp8.match_cnt), 32'(m_cnt8));
        check("cnt2", 32'(sp2.match_cnt), 32'(m_cnt2));
        check("cur_len", 32'(sp8.cur_len), 32'(m_len));
    endtask

    task automatic bitin(input bit d);
        step(1'b1, d, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input bit [3:0] p, input bit [2:0] l, input bit o);
        step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0, 1'b0);
    endtask

    task automatic stream(input bit [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bitin(bits[i]);
    endtask

    initial begin
        t_valid = 0; t_din = 0; t_load = 0; t_pat = 0; t_len = 0; t_ovl = 0; t_clr = 0; rst = 1;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_match", 32'(sp8.match), 32'd0);
        check("rst_len", 32'(sp8.cur_len), 32'd4);

        // Overlapping default pattern 1011 over 1011011
        stream(16'b1011011, 7);
        check("t1_cnt", 32'(sp8.match_cnt), 32'd2);

        // Non-overlapping
        step(0, 0, 1, 4'b1011, 3'd4, 0, 1, 0);
        stream(16'b1011011, 7);
        check("t2_cnt", 32'(sp8.match_cnt), 32'd1);

        // Gaps in din_valid are transparent
        load(4'b1011, 3'd4, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            bitin(4'b1011 >> i);
            if (i != 0) repeat (3) idle();
        end
        idle();

        // Short pattern, then len 0 clamps to 1
        load(4'b0111, 3'd3, 1'b1);
        stream(16'b1111, 4);
        check("t4_len3", 32'(sp8.cur_len), 32'd3);
        load(4'b0111, 3'd0, 1'b1);
        check("t4_len1", 32'(sp8.cur_len), 32'd1);
        stream(16'b1101, 4);
        load(4'b1011, 3'd7, 1'b1);
        check("t4_clamp", 32'(sp8.cur_len), 32'd4);

        // Reset mid-stream discards partial match and restores pattern
        stream(16'b101, 3);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        bitin(1'b1);
        check("t5_cnt", 32'(sp8.match_cnt), 32'd0);
        stream(16'b011, 3);
        check("t5_pat", 32'(sp8.match), 32'd1);

        // Bit coincident with cfg_load is dropped
        load(4'b1011, 3'd4, 1'b0);
        stream(16'b101, 3);
        step(1, 1, 1, 4'b1011, 3'd4, 0, 0, 0);
        bitin(1'b1);
        check("t5_drop", 32'(sp8.match), 32'd0);
        stream(16'b011, 3);

        // Saturation of the 2-bit counter and clear interaction
        load(4'b0001, 3'd1, 1'b1);
        stream(16'b11111, 5);
        check("t6_sat", 32'(sp2.match_cnt), 32'd3);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        check("t6_clrhit", 32'(sp2.match_cnt), 32'd1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        check("t6_clr", 32'(sp8.match_cnt), 32'd0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 3)
                step(0, 0, 0, 0, 0, 0, 0, 1);
            else if (sel < 8)
                step(1'($urandom), 1'($urandom), 1, 4'($urandom), 3'($urandom), 1'($urandom), 0, 0);
            else
                step(($urandom_range(0, 3) != 0), 1'($urandom), 0, 0, 0, 0,
                     ($urandom_range(0, 29) == 0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
